// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if
//   Bundles the request/lock/data inputs and the grant/register outputs of
//   the shared register arbiter. clk and reset remain plain module ports.
//   req    : per-requester write request (bit i = requester i)
//   lock   : per-requester ownership-hold request
//   wdata  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    : registered one-hot write acknowledge
//   q      : shared register contents
//   owner  : index of the last granted requester
//   locked : high while a requester holds ownership
//   master : requester side (drives req/lock/wdata)
//   slave  : arbiter side (drives gnt/q/owner/locked)
interface shared_reg_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [3:0]         lock;
  logic [4*WIDTH-1:0] wdata;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   q;
  logic [1:0]         owner;
  logic               locked;

  modport master (
    output req, lock, wdata,
    input  gnt, q, owner, locked
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, owner, locked
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Four requesters share one WIDTH-bit register. Each clk edge a round-robin
//   arbiter picks one writer; a winner that also raises lock keeps exclusive
//   access until it drops lock.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : shared_reg_arbiter_if.slave (req, lock, wdata in; gnt, q,
//           owner, locked out)
//
//   state | meaning
//   IDLE  | round-robin arbitration among all requesters
//   OWNED | only the owner is served; others are ignored
module shared_reg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  shared_reg_arbiter_if.slave    bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       owner_r, owner_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [3:0]       gnt_r, gnt_nxt;
  logic [1:0]       win;
  logic             win_vld;

  // Scan from the highest offset down so the requester closest to ptr
  // is the last assignment and therefore wins.
  always_comb begin
    logic [1:0] idx;
    win     = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner_r;
    q_nxt     = q_r;
    gnt_nxt   = 4'b0000;
    if (state == OWNED && bus.lock[owner_r]) begin
      if (bus.req[owner_r]) begin
        q_nxt            = bus.wdata[owner_r*WIDTH +: WIDTH];
        gnt_nxt[owner_r] = 1'b1;
      end
    end else begin
      // Releasing the lock falls straight into normal arbitration. ptr
      // already equals owner+1 here because OWNED is only entered on a win.
      state_nxt = IDLE;
      if (win_vld) begin
        q_nxt        = bus.wdata[win*WIDTH +: WIDTH];
        gnt_nxt[win] = 1'b1;
        owner_nxt    = win;
        ptr_nxt      = win + 2'd1;
        if (bus.lock[win]) begin
          state_nxt = OWNED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      owner_r <= 2'd0;
      q_r     <= '0;
      gnt_r   <= 4'b0000;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner_r <= owner_nxt;
      q_r     <= q_nxt;
      gnt_r   <= gnt_nxt;
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.q      = q_r;
  assign bus.owner  = owner_r;
  assign bus.locked = (state == OWNED);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
//   Directed scenarios followed by randomized traffic, all compared against
//   a behavioural model of the arbitration rules kept in this bench.
module tb_shared_reg_arbiter;
  localparam int WIDTH = 8;

  logic clk;
  logic reset;

  shared_reg_arbiter_if #(.WIDTH(WIDTH)) bus ();

  shared_reg_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int       m_q;
  int       m_gnt;
  int       m_owner;
  int       m_ptr;
  bit       m_locked;
  bit [7:0] d [4];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_gnt = 0; m_owner = 0; m_ptr = 0; m_locked = 1'b0;
  endtask

  task automatic model_edge(input bit [3:0] rq, input bit [3:0] lk);
    int w;
    m_gnt = 0;
    if (m_locked && lk[m_owner]) begin
      if (rq[m_owner]) begin
        m_q   = d[m_owner];
        m_gnt = 1 << m_owner;
      end
    end else begin
      m_locked = 1'b0;
      w = -1;
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && rq[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      end
      if (w >= 0) begin
        m_q      = d[w];
        m_gnt    = 1 << w;
        m_owner  = w;
        m_ptr    = (w + 1) % 4;
        m_locked = lk[w];
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},    int'(bus.gnt),    m_gnt);
    chk({tag, ".q"},      int'(bus.q),      m_q);
    chk({tag, ".owner"},  int'(bus.owner),  m_owner);
    chk({tag, ".locked"}, int'(bus.locked), int'(m_locked));
  endtask

  // drive inputs, take one edge, update model, compare
  task automatic step(input string tag, input bit [3:0] rq, input bit [3:0] lk);
    bus.req   = rq;
    bus.lock  = lk;
    bus.wdata = {d[3], d[2], d[1], d[0]};
    @(posedge clk);
    #1;
    model_edge(rq, lk);
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    #2 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.req   = 4'b0;
    bus.lock  = 4'b0;
    bus.wdata = '0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // load 0x5A then reset mid-cycle
    d[0] = 8'h5A;
    step("load5a", 4'b0001, 4'b0000);
    chk("load5a.q_const", int'(bus.q), 'h5A);
    do_reset();
    chk("rst.q_const", int'(bus.q), 0);

    // single requester
    d[2] = 8'h3C;
    step("single", 4'b0100, 4'b0000);
    chk("single.gnt_const", int'(bus.gnt), 'b0100);
    step("single_after", 4'b0000, 4'b0000);
    chk("single_after.q_const", int'(bus.q), 'h3C);

    // rotation from ptr=0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'(16 * k + i + 1);
      step("rotate", 4'b1111, 4'b0000);
    end
    chk("rotate.gnt_last", int'(bus.gnt), 'b0001);

    // lock hold by requester 1
    do_reset();
    d[1] = 8'h11;
    step("lock_win", 4'b0010, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      step("lock_hold", 4'b1111, 4'b1111);
    end
    chk("lock_hold.locked_const", int'(bus.locked), 1);
    step("lock_drop", 4'b1111, 4'b0000);
    chk("lock_drop.gnt_const", int'(bus.gnt), 'b0100);

    // owner idle while locked
    step("lock_win3", 4'b1000, 4'b1000);
    step("lock_noreq", 4'b0111, 4'b1111);

    // idle hold
    for (int k = 0; k < 4; k++) step("idle", 4'b0000, 4'b0000);

    // reset during ownership
    step("lock3", 4'b1000, 4'b1000);
    do_reset();
    step("post_rst", 4'b1001, 4'b0000);
    chk("post_rst.gnt_const", int'(bus.gnt), 'b0001);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      bit [3:0] rq;
      bit [3:0] lk;
      rq = 4'($urandom_range(0, 15));
      lk = 4'b0;
      for (int i = 0; i < 4; i++) lk[i] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) do_reset();
      step("rand", rq, lk);
      chk("rand.onehot", int'($countones(bus.gnt) <= 1), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
